// File: rtl/spi_flash_cmd_seq.sv
// SPI flash command sequencer: turns one flash command into a byte stream for the
// byte-level SPI master, with optional WREN prefix, FAST_READ dummies and WIP polling.
module spi_flash_cmd_seq #(
    parameter int ADDR_BYTES  = 3,
    parameter int SIZE_W      = 9,
    parameter int DUMMY_BYTES = 1,
    parameter int AUTO_WREN   = 1,
    parameter int POLL_EN     = 1,
    parameter int POLL_MAX    = 65535,
    parameter int CS_GAP      = 2
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    input  logic [7:0]              cmd,
    input  logic                    cmd_valid,
    output logic                    cmd_ack,
    output logic                    cmd_err,
    input  logic [8*ADDR_BYTES-1:0] addr,
    input  logic [SIZE_W-1:0]       size,
    input  logic [7:0]              data_in,
    output logic                    data_req,
    output logic [7:0]              data_out,
    output logic                    data_valid,
    output logic                    busy,
    output logic                    CS_reg,
    output logic                    wr_req,
    input  logic                    wr_ack,
    output logic [7:0]              send_data,
    input  logic [7:0]              data_recv
);
    localparam int CNT_W  = SIZE_W + 1;
    localparam int POLL_W = $clog2(POLL_MAX + 1);
    localparam int GAP_W  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((CS_GAP > 0) ? CS_GAP - 1 : 0);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);
    localparam logic [POLL_W-1:0] POLL_TOP  = POLL_W'(POLL_MAX);

    localparam logic [3:0] IDLE        = 4'd0;
    localparam logic [3:0] LATCH       = 4'd1;
    localparam logic [3:0] WREN_FRAME  = 4'd2;
    localparam logic [3:0] GAP         = 4'd3;
    localparam logic [3:0] CS_LOW      = 4'd4;
    localparam logic [3:0] OPCODE      = 4'd5;
    localparam logic [3:0] ADDR        = 4'd6;
    localparam logic [3:0] DUMMY       = 4'd7;
    localparam logic [3:0] XFER        = 4'd8;
    localparam logic [3:0] CS_HIGH     = 4'd9;
    localparam logic [3:0] POLL_OPCODE = 4'd10;
    localparam logic [3:0] POLL_READ   = 4'd11;
    localparam logic [3:0] ACK         = 4'd12;

    // Which frame just closed; decides where CS_HIGH goes next.
    localparam logic [1:0] PH_WREN = 2'd0;
    localparam logic [1:0] PH_MAIN = 2'd1;
    localparam logic [1:0] PH_POLL = 2'd2;

    logic [3:0]              state;
    logic [1:0]              phase;
    logic [7:0]              cmd_q;
    logic [8*ADDR_BYTES-1:0] addr_q;
    logic                    has_addr, is_write, need_poll, err_q;
    logic [CNT_W-1:0]        dum_n, xfer_n, byte_cnt;
    logic [POLL_W-1:0]       poll_cnt;
    logic [GAP_W-1:0]        gap_cnt;

    logic                    d_bad, d_addr, d_dummy, d_write, d_wren, d_poll;
    logic [CNT_W-1:0]        d_xfer, nbytes;
    logic [3:0]              after_op, after_addr, after_dummy, byte_next;
    logic [7:0]              tx_byte;
    logic                    in_byte, last_byte;

    always_comb begin
        d_bad = 1'b0; d_addr = 1'b0; d_dummy = 1'b0; d_write = 1'b0;
        d_wren = 1'b0; d_poll = 1'b0; d_xfer = '0;
        case (cmd)
            8'h06, 8'h04: begin end
            8'hC7: begin d_wren = 1'b1; d_poll = 1'b1; end
            8'h05, 8'h9F: d_xfer = {1'b0, size};
            8'h03: begin d_addr = 1'b1; d_xfer = {1'b0, size}; end
            8'h0B: begin d_addr = 1'b1; d_dummy = 1'b1; d_xfer = {1'b0, size}; end
            8'h01: begin d_xfer = CNT_W'(1); d_write = 1'b1; d_wren = 1'b1; d_poll = 1'b1; end
            8'h02: begin
                d_addr = 1'b1; d_xfer = {1'b0, size};
                d_write = 1'b1; d_wren = 1'b1; d_poll = 1'b1;
            end
            8'hD8: begin d_addr = 1'b1; d_wren = 1'b1; d_poll = 1'b1; end
            default: d_bad = 1'b1;
        endcase
    end

    always_comb begin
        after_dummy = (xfer_n != '0) ? XFER : CS_HIGH;
        after_addr  = (dum_n != '0) ? DUMMY : after_dummy;
        after_op    = has_addr ? ADDR : after_addr;
        in_byte     = 1'b1;
        byte_next   = CS_HIGH;
        nbytes      = CNT_W'(1);
        tx_byte     = 8'h00;
        case (state)
            WREN_FRAME:  tx_byte = 8'h06;
            OPCODE:      begin tx_byte = cmd_q; byte_next = after_op; end
            ADDR:        begin
                tx_byte = addr_q[8*ADDR_BYTES-1 -: 8];
                byte_next = after_addr; nbytes = CNT_W'(ADDR_BYTES);
            end
            DUMMY:       begin byte_next = after_dummy; nbytes = dum_n; end
            XFER:        begin tx_byte = is_write ? data_in : 8'h00; nbytes = xfer_n; end
            POLL_OPCODE: begin tx_byte = 8'h05; byte_next = POLL_READ; end
            POLL_READ:   begin end
            default:     in_byte = 1'b0;
        endcase
        last_byte = (byte_cnt + CNT_W'(1)) == nbytes;
    end

    assign busy    = (state != IDLE);
    assign cmd_ack = (state == ACK);
    assign cmd_err = (state == ACK) && err_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE; phase <= PH_MAIN; cmd_q <= '0; addr_q <= '0;
            has_addr <= 1'b0; is_write <= 1'b0; need_poll <= 1'b0; err_q <= 1'b0;
            dum_n <= '0; xfer_n <= '0; byte_cnt <= '0; poll_cnt <= '0; gap_cnt <= '0;
            CS_reg <= 1'b1; wr_req <= 1'b0; send_data <= '0;
            data_req <= 1'b0; data_out <= '0; data_valid <= 1'b0;
        end else begin
            data_req   <= 1'b0;
            data_valid <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) state <= LATCH;
                LATCH: begin
                    cmd_q <= cmd; addr_q <= addr; has_addr <= d_addr; is_write <= d_write;
                    need_poll <= d_poll && (POLL_EN != 0);
                    dum_n <= d_dummy ? CNT_W'(DUMMY_BYTES) : '0;
                    xfer_n <= d_xfer; err_q <= 1'b0;
                    byte_cnt <= '0; poll_cnt <= '0; gap_cnt <= '0;
                    if (d_bad) begin
                        err_q <= 1'b1; state <= ACK;
                    end else if (d_wren && (AUTO_WREN != 0)) begin
                        phase <= PH_WREN; CS_reg <= 1'b0; state <= WREN_FRAME;
                    end else begin
                        phase <= PH_MAIN; state <= CS_LOW;
                    end
                end
                CS_LOW: begin CS_reg <= 1'b0; state <= OPCODE; end
                CS_HIGH: begin
                    CS_reg <= 1'b1;
                    case (phase)
                        PH_WREN: begin phase <= PH_MAIN; state <= GAP; end
                        PH_MAIN: if (need_poll) begin phase <= PH_POLL; state <= GAP; end
                                 else state <= ACK;
                        default: state <= ACK;
                    endcase
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        if (phase == PH_POLL) begin CS_reg <= 1'b0; state <= POLL_OPCODE; end
                        else state <= CS_LOW;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                ACK: state <= IDLE;
                default: begin
                    if (!in_byte) begin
                        state <= IDLE;
                    end else if (!wr_req) begin
                        wr_req <= 1'b1;
                        send_data <= tx_byte;
                        if (state == XFER && is_write) data_req <= 1'b1;
                        if (state == ADDR) addr_q <= addr_q << 8;
                    end else if (wr_ack) begin
                        wr_req <= 1'b0;
                        if (state == XFER && !is_write) begin
                            data_out <= data_recv; data_valid <= 1'b1;
                        end
                        if (state == POLL_READ) begin
                            if (poll_cnt != POLL_TOP) poll_cnt <= poll_cnt + POLL_W'(1);
                            if (!data_recv[0]) begin
                                CS_reg <= 1'b1; state <= CS_HIGH;
                            end else if (poll_cnt == POLL_LAST) begin
                                err_q <= 1'b1; CS_reg <= 1'b1; state <= CS_HIGH;
                            end
                        end else if (last_byte) begin
                            byte_cnt <= '0;
                            state <= byte_next;
                            if (byte_next == CS_HIGH) CS_reg <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end
endmodule
